// File: rtl/pipe_cla_adder_if.sv
// rtl/pipe_cla_adder_if.sv - operand/result handshake bundle for pipe_cla_adder
// Purpose: groups the operand beat and the result beat of the adder.
// Signals:
//   inValid/inReady     operand beat handshake
//   in1/in2/cIn/subMode operands, carry-in, 1 = subtract
//   outValid/outReady   result beat handshake
//   sum/cOut/ovf/zero   result, carry out (1 = no borrow), signed overflow, sum==0
//   GG/PG               full-width group generate/propagate
// Modports: master = operand producer / result consumer, slave = the adder.
interface pipe_cla_adder_if #(
  parameter int WIDTH = 32
);
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cIn;
  logic             subMode;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] sum;
  logic             cOut;
  logic             ovf;
  logic             zero;
  logic             GG;
  logic             PG;

  modport master (
    output inValid, in1, in2, cIn, subMode, outReady,
    input  inReady, outValid, sum, cOut, ovf, zero, GG, PG
  );

  modport slave (
    input  inValid, in1, in2, cIn, subMode, outReady,
    output inReady, outValid, sum, cOut, ovf, zero, GG, PG
  );
endinterface

// File: rtl/pipe_cla_adder.sv
// rtl/pipe_cla_adder.sv - pipelined two-level carry-lookahead adder/subtractor
// Purpose: computes in1 + in2 + cIn (subMode=0) or in1 - in2 (subMode=1) with
//   4-bit CLA blocks and a block-level lookahead unit, over STAGES register
//   stages with valid/ready flow control.
// Parameters: WIDTH (multiple of 4, >= 8), STAGES (1..4).
// Ports: clk, rst (synchronous, active-high), bus (pipe_cla_adder_if.slave).
// Build option: define PIPE_CLA_SAT_EN for signed saturation on overflow.
module pipe_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_cla_adder_if.slave       bus
);
  localparam int NB  = WIDTH / 4;
  localparam int MSB = WIDTH - 1;
  // Stage index at which each layer is evaluated. With 4 stages the extra
  // register sits in front of the block P/G layer.
  localparam int L_PG  = (STAGES == 4) ? 1 : 0;
  localparam int L_CY  = (STAGES == 1) ? 0 : ((STAGES == 4) ? 2 : 1);
  localparam int L_SUM = STAGES - 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;    // effective operand B
    logic             c0;   // effective carry-in
    logic [NB-1:0]    bp;
    logic [NB-1:0]    bg;
    logic [NB:0]      bc;   // carry into each block; bc[NB] is the carry out
    logic             gg;
    logic             pg;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
    logic             z;
  } stage_t;

  function automatic stage_t f_prep(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                    logic cin, logic sub);
    stage_t y = '0;
    y.a  = a;
    y.b  = sub ? ~b : b;
    y.c0 = sub ? 1'b1 : cin;
    return y;
  endfunction

  function automatic stage_t f_pg(stage_t x);
    stage_t y = x;
    logic [3:0] p;
    logic [3:0] g;
    for (int k = 0; k < NB; k++) begin
      p = x.a[4*k +: 4] ^ x.b[4*k +: 4];
      g = x.a[4*k +: 4] & x.b[4*k +: 4];
      y.bp[k] = &p;
      y.bg[k] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    end
    return y;
  endfunction

  // Lookahead unit: every block carry is a flat OR of "block j generates and
  // all blocks above j propagate" terms plus the propagated carry-in, so no
  // carry ripples through lower blocks. The carry-in-free term at k=NB is GG.
  function automatic stage_t f_cy(stage_t x);
    stage_t y = x;
    logic g_acc;
    logic p_all;
    logic term;
    for (int k = 0; k <= NB; k++) begin
      g_acc = 1'b0;
      p_all = 1'b1;
      for (int j = 0; j < k; j++) begin
        term = x.bg[j];
        for (int m = j + 1; m < k; m++) term = term & x.bp[m];
        g_acc = g_acc | term;
        p_all = p_all & x.bp[j];
      end
      y.bc[k] = g_acc | (p_all & x.c0);
      if (k == NB) begin
        y.gg = g_acc;
        y.pg = p_all;
      end
    end
    return y;
  endfunction

  function automatic stage_t f_sum(stage_t x);
    stage_t y = x;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic c;
    p = x.a ^ x.b;
    g = x.a & x.b;
    for (int k = 0; k < NB; k++) begin
      c = x.bc[k];
      for (int i = 0; i < 4; i++) begin
        y.s[4*k+i] = p[4*k+i] ^ c;
        c = g[4*k+i] | (p[4*k+i] & c);
      end
    end
    y.co = x.bc[NB];
    y.ov = (x.a[MSB] == x.b[MSB]) && (y.s[MSB] != x.a[MSB]);
`ifdef PIPE_CLA_SAT_EN
    if (y.ov) y.s = x.a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    y.z = (y.s == '0);
    return y;
  endfunction

  function automatic stage_t f_layer(int idx, stage_t x);
    stage_t y = x;
    if (idx == L_PG)  y = f_pg(y);
    if (idx == L_CY)  y = f_cy(y);
    if (idx == L_SUM) y = f_sum(y);
    return y;
  endfunction

  stage_t            r   [STAGES];
  stage_t            nxt [STAGES];
  logic [STAGES-1:0] vld;
  logic              adv;

  // Reset forces advance so inReady reads 1 during reset; the reset branch
  // below still wins, so nothing is captured while rst=1.
  assign adv         = rst | ~vld[STAGES-1] | bus.outReady;
  assign bus.inReady = adv;

  always_comb begin
    nxt[0] = f_layer(0, f_prep(bus.in1, bus.in2, bus.cIn, bus.subMode));
    for (int i = 1; i < STAGES; i++) nxt[i] = f_layer(i, r[i-1]);
  end

  // Whole pipeline moves in lockstep, so bubbles travel as invalid slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) r[i] <= '0;
    end else if (adv) begin
      vld[0] <= bus.inValid;
      for (int i = 1; i < STAGES; i++) vld[i] <= vld[i-1];
      for (int i = 0; i < STAGES; i++) r[i] <= nxt[i];
    end
  end

  assign bus.outValid = vld[STAGES-1];
  assign bus.sum      = r[STAGES-1].s;
  assign bus.cOut     = r[STAGES-1].co;
  assign bus.ovf      = r[STAGES-1].ov;
  assign bus.zero     = r[STAGES-1].z;
  assign bus.GG       = r[STAGES-1].gg;
  assign bus.PG       = r[STAGES-1].pg;
endmodule

// File: tb/tb_pipe_cla_adder.sv
// tb/tb_pipe_cla_adder.sv - scoreboard testbench for pipe_cla_adder
module tb_pipe_cla_adder;
  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
`ifdef PIPE_CLA_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  logic clk;
  logic rst;

  pipe_cla_adder_if #(.WIDTH(WIDTH)) bus ();

  pipe_cla_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
    logic        gg;
    logic        pg;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  function automatic exp_t mk(logic [31:0] s, logic co, logic ov, logic z, logic gg, logic pg);
    exp_t e;
    e.s = s; e.co = co; e.ov = ov; e.z = z; e.gg = gg; e.pg = pg;
    return e;
  endfunction

  function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic cin, logic sub);
    exp_t        e;
    logic [31:0] be;
    logic [32:0] full;
    logic [32:0] nocin;
    be    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, be} + {32'd0, (sub ? 1'b1 : cin)};
    nocin = {1'b0, a} + {1'b0, be};
    e.s   = full[31:0];
    e.co  = full[32];
    e.ov  = (a[31] == be[31]) && (full[31] != a[31]);
    e.gg  = nocin[32];
    e.pg  = &(a ^ be);
`ifdef PIPE_CLA_SAT_EN
    if (e.ov) e.s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    e.z   = (e.s == 32'd0);
    return e;
  endfunction

  // Monitor: pops and compares every delivered beat; checks stall stability.
  initial begin
    exp_t cur;
    exp_t e;
    exp_t held;
    logic held_v;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        cur.s = bus.sum; cur.co = bus.cOut; cur.ov = bus.ovf;
        cur.z = bus.zero; cur.gg = bus.GG; cur.pg = bus.PG;
        if (held_v) begin
          chk("stall_outvalid", {31'd0, bus.outValid}, 32'd1);
          chk("stall_sum", cur.s, held.s);
          chk("stall_flags", {27'd0, cur.co, cur.ov, cur.z, cur.gg, cur.pg},
              {27'd0, held.co, held.ov, held.z, held.gg, held.pg});
        end
        if (bus.outValid && !bus.outReady) begin
          chk("stall_inready", {31'd0, bus.inReady}, 32'd0);
          held_v = 1'b1;
          held   = cur;
        end else begin
          held_v = 1'b0;
        end
        if (bus.outValid && bus.outReady) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual sum=0x%08h required=no beat", cur.s);
          end else begin
            e = sbq.pop_front();
            chk("sum", cur.s, e.s);
            chk("flags{cOut,ovf,zero,GG,PG}", {27'd0, cur.co, cur.ov, cur.z, cur.gg, cur.pg},
                {27'd0, e.co, e.ov, e.z, e.gg, e.pg});
          end
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic sub, input logic push, input exp_t e, output logic acc);
    bus.inValid = 1'b1;
    bus.in1 = a; bus.in2 = b; bus.cIn = cin; bus.subMode = sub;
    @(negedge clk);
    acc = bus.inReady;
    if (acc && push) sbq.push_back(e);
    cycle();
    bus.inValid = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input logic sub, input exp_t e);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) drive(a, b, cin, sub, 1'b1, e, acc);
    chk("accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic drain();
    bus.outReady = 1'b1;
    for (int t = 0; t < 100 && sbq.size() != 0; t++) cycle();
    repeat (4) cycle();
    chk("drain_empty", sbq.size(), 32'd0);
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic        acc;
    int          lat;
    int          sent;
    int          cyc;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic        rs;

    rst = 1'b1;
    bus.outReady = 1'b1;
    // A beat offered during reset must not be captured.
    bus.inValid = 1'b1; bus.in1 = 32'd8; bus.in2 = 32'd1; bus.cIn = 1'b0; bus.subMode = 1'b0;
    cycle();
    cycle();
    @(negedge clk);
    chk("reset_inready", {31'd0, bus.inReady}, 32'd1);
    chk("reset_outvalid", {31'd0, bus.outValid}, 32'd0);
    chk("reset_sum", bus.sum, 32'd0);
    chk("reset_flags", {27'd0, bus.cOut, bus.ovf, bus.zero, bus.GG, bus.PG}, 32'd0);
    cycle();
    rst = 1'b0;
    bus.inValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_idle", {31'd0, bus.outValid}, 32'd0);
      cycle();
    end

    // First add with latency measurement.
    drive(32'd10, 32'd8, 1'b0, 1'b0, 1'b1, mk(32'd18, 0, 0, 0, 0, 0), acc);
    chk("add_accept", {31'd0, acc}, 32'd1);
    lat = 1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (bus.outValid) break;
      lat++;
      cycle();
    end
    chk("latency", lat, STAGES);
    cycle();

    // Directed vectors back to back.
    send(32'd5, 32'd23, 1'b0, 1'b1, mk(32'hFFFF_FFEE, 0, 0, 0, 0, 0));
    send(32'd23, 32'd23, 1'b0, 1'b1, mk(32'd0, 1, 0, 1, 0, 1));
    send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0,
         mk(SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 0, 1, 0, 0, 0));
    send(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, mk(32'd0, 1, 0, 1, 0, 1));
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
         mk(SAT ? 32'h8000_0000 : 32'd0, 1, 1, SAT ? 1'b0 : 1'b1, 1, 0));
    send(32'd10, 32'd3, 1'b1, 1'b1, mk(32'd7, 1, 0, 0, 1, 0));
    drain();

    // Backpressure: two beats, then three stalled cycles.
    drive(32'd123, 32'd70, 1'b1, 1'b0, 1'b1, mk(32'd194, 0, 0, 0, 0, 0), acc);
    chk("bp_accept_a", {31'd0, acc}, 32'd1);
    bus.outReady = 1'b0;
    drive(32'd11, 32'd22, 1'b0, 1'b0, 1'b1, mk(32'd33, 0, 0, 0, 0, 0), acc);
    chk("bp_accept_b", {31'd0, acc}, 32'd1);
    @(negedge clk);
    chk("bp_outvalid", {31'd0, bus.outValid}, 32'd1);
    chk("bp_sum", bus.sum, 32'd194);
    chk("bp_inready", {31'd0, bus.inReady}, 32'd0);
    cycle();
    cycle();
    cycle();
    drain();

    // Reset while a beat is in flight: it must vanish.
    drive(32'd8, 32'd1, 1'b0, 1'b0, 1'b0, mk(32'd9, 0, 0, 0, 0, 0), acc);
    chk("flush_accept", {31'd0, acc}, 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flush_outvalid", {31'd0, bus.outValid}, 32'd0);
      cycle();
    end

    // Random stream with random gaps and backpressure.
    sent = 0;
    cyc  = 0;
    bus.inValid = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      bus.outReady = ($urandom_range(0, 3) != 0);
      if (!bus.inValid && $urandom_range(0, 3) != 0) begin
        ra = rand_op(); rb = rand_op(); rc = $urandom_range(0, 1); rs = $urandom_range(0, 1);
        bus.in1 = ra; bus.in2 = rb; bus.cIn = rc; bus.subMode = rs;
        bus.inValid = 1'b1;
      end
      @(negedge clk);
      acc = bus.inValid && bus.inReady;
      if (acc) begin
        sbq.push_back(model(ra, rb, rc, rs));
        sent++;
      end
      cycle();
      cyc++;
      if (acc) bus.inValid = 1'b0;
    end
    chk("random_sent", sent, 32'd1000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter STAGES, default 2, number of register stages from input acceptance to output (1..4).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 inValid  input  1  operand beat present on in1/in2/cIn/subMode.
REQ-006 inReady  output  1  block accepts the beat this cycle.
REQ-007 in1  input  WIDTH  operand A.
REQ-008 in2  input  WIDTH  operand B.
REQ-009 cIn  input  1  carry-in, used only when subMode=0.
REQ-010 subMode  input  1  1 = A minus B, 0 = A plus B plus cIn.
REQ-011 outValid  output  1  result beat present.
REQ-012 outReady  input  1  downstream accepts the result beat.
REQ-013 sum  output  WIDTH  result.
REQ-014 cOut  output  1  carry out of the MSB; in subtract mode 1 = no borrow.
REQ-015 ovf  output  1  signed two's-complement overflow.
REQ-016 zero  output  1  sum == 0.
REQ-017 GG  output  1  group generate over the full width.
REQ-018 PG  output  1  group propagate over the full width.

Function
REQ-019 Effective operand B SHALL be in2 when subMode=0 and ~in2 when subMode=1; the effective carry-in SHALL be cIn when subMode=0 and 1 when subMode=1.
REQ-020 Carries SHALL be computed as a two-level lookahead: 4-bit CLA blocks produce block P/G, and a lookahead unit combines them into block carries; GG and PG SHALL be the top-level group generate/propagate of A and effective B, independent of carry-in.
REQ-021 sum SHALL equal (A + effective B + effective carry-in) mod 2^WIDTH.
REQ-022 ovf SHALL be (A[MSB] == effB[MSB]) && (sum[MSB] != A[MSB]).
REQ-023 Pipeline advance condition adv = !outValid || outReady; inReady SHALL equal adv combinationally, with no dependence on inValid.
REQ-024 A beat SHALL be accepted when inValid && inReady; its result SHALL be presented with outValid=1 exactly STAGES cycles later if adv stays 1 throughout.
REQ-025 When adv=0, all stage registers and their valid bits SHALL hold; outputs SHALL remain stable until accepted.
REQ-026 Each stage SHALL carry a valid bit; bubbles SHALL propagate as invalid slots and SHALL NOT be collapsed; with STAGES>1 the register boundaries SHALL fall between the block-P/G, carry, and sum/flag layers.
REQ-027 Results SHALL be delivered in acceptance order, with no loss or duplication, under any pattern of inValid/outReady.
REQ-028 Sustained throughput SHALL be one beat per cycle when outReady=1.

Reset
REQ-029 While rst=1, all stage valid bits SHALL clear, and outValid, sum, cOut, ovf, zero, GG, and PG SHALL be 0 on the following edge.
REQ-030 A reset mid-operation SHALL discard all in-flight beats; no stale result SHALL appear after rst deasserts.
REQ-031 During reset inReady SHALL be 1, but no beat SHALL be captured in a cycle where rst=1.

Configuration
REQ-032 Macro PIPE_CLA_SAT_EN, when defined, SHALL enable signed saturation: on ovf=1, sum SHALL be 0x7F..F for a positive overflow (A[MSB]=0) or 0x80..0 for a negative overflow, with ovf still reported as 1 and zero computed on the saturated value.
REQ-033 Without PIPE_CLA_SAT_EN, sum SHALL wrap per REQ-021, and no saturation logic SHALL be synthesised.

Verification (WIDTH=32, STAGES=2)
REQ-034 Add: in1=10, in2=8, cIn=0, subMode=0, outReady=1 -> 2 cycles later outValid=1, sum=18, cOut=0, ovf=0, zero=0.
REQ-035 Sub: in1=5, in2=23, subMode=1 -> sum=0xFFFFFFEE, cOut=0, ovf=0; then in1=23, in2=23 -> sum=0, zero=1, cOut=1.
REQ-036 Overflow: in1=0x7FFFFFFF, in2=1, cIn=0 -> sum=0x80000000, ovf=1, or 0x7FFFFFFF with PIPE_CLA_SAT_EN defined; in1=0xFFFFFFFF, in2=0, cIn=1 -> sum=0, cOut=1, PG=1, GG=0.
REQ-037 Backpressure: stream 123+70+1 and 11+22 back-to-back, hold outReady=0 for 3 cycles -> inReady=0 while outValid=1, outputs stable at 194; on release 194 then 33 in order, once each.
REQ-038 Reset mid-flight: accept 8+1, assert rst the next cycle for 1 cycle -> outValid stays 0 and 9 never appears.
REQ-039 Random back-to-back stream of 1000 beats with random inValid/outReady -> scoreboard matches the reference sum/flags in order.
